// File: rtl/xgriscv_memarb.sv
// xgriscv_memarb
// Shares one single-port, ready-handshake memory between the instruction-fetch
// port and the load/store port. Only one access is in flight at a time. When
// both ports request at once, round-robin picks the winner. The winner gets its
// read data and a one-cycle ack. `stall` holds the core until its access is done.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   if_req/if_addr      : fetch request and address (held until if_ack)
//   if_rdata/if_ack     : fetched word (held until next fetch), completion pulse
//   d_req/d_we/d_addr   : data request, 1 = store, address (held until d_ack)
//   d_wdata/d_be        : store data, byte enables
//   d_rdata/d_ack       : load data (loads only), completion pulse
//   mem_req..mem_be     : registered memory request and payload
//   mem_rdata/mem_ready : memory read data, access-complete strobe
//   stall               : a request is pending and has not been acked yet
module xgriscv_memarb #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [ADDR_SIZE-1:0] if_addr,
    output logic [XLEN-1:0]      if_rdata,
    output logic                 if_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_SIZE-1:0] d_addr,
    input  logic [XLEN-1:0]      d_wdata,
    input  logic [3:0]           d_be,
    output logic [XLEN-1:0]      d_rdata,
    output logic                 d_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [3:0]           mem_be,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 mem_ready,
    output logic                 stall
);

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

    state_e state;
    logic   gnt_d;   // current grant belongs to the data port
    logic   last_d;  // previous grant went to the data port
    logic   pick_d;

    // A lone data request always wins. On a tie, data wins only if fetch went last.
    assign pick_d = d_req & (~if_req | ~last_d);

    assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            gnt_d     <= 1'b0;
            last_d    <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (if_req || d_req) begin
                        state   <= StBusy;
                        mem_req <= 1'b1;
                        gnt_d   <= pick_d;
                        last_d  <= pick_d;
                        if (pick_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                        end else begin
                            // mem_wdata keeps its old value; it is unused on a read.
                            mem_we   <= 1'b0;
                            mem_addr <= if_addr;
                            mem_be   <= 4'b1111;
                        end
                    end
                end
                StBusy: begin
                    if (mem_ready) begin
                        state   <= StAck;
                        mem_req <= 1'b0;
                        if (gnt_d) begin
                            d_ack <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                StAck: begin
                    // Do not grant here. The acked requester may still hold req high this cycle.
                    state <= StIdle;
                end
                default: begin
                    state   <= StIdle;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
